// File: rtl/fu_mem_pipe_if.sv
// ---------------------------------------------------------------------------
// fu_mem_pipe_if
//   Issue/writeback bundle of the pipelined load/store functional unit.
//
//   Handshake: the issue side raises EN with the operands; the request is
//   taken on a rising edge where EN=1 and ready=1. EN while ready=0 is
//   dropped with no effect. Completion is a one-cycle finish pulse carrying
//   mem_data, tag_out and fault. There is no back-pressure on finish.
//
//   Signals (issue side -> unit): EN, mem_w, bhw, tag_in, rs1_data,
//     rs2_data, imm
//   Signals (unit -> issue/writeback side): ready, finish, mem_data,
//     tag_out, fault
//   Modports: master = issue stage / bench, slave = the unit
// ---------------------------------------------------------------------------
interface fu_mem_pipe_if #(
  parameter int TAG_W = 4
);
  logic             EN;
  logic             mem_w;
  logic [2:0]       bhw;
  logic [TAG_W-1:0] tag_in;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic [31:0]      imm;
  logic             ready;
  logic             finish;
  logic [31:0]      mem_data;
  logic [TAG_W-1:0] tag_out;
  logic             fault;

  modport master (
    output EN, mem_w, bhw, tag_in, rs1_data, rs2_data, imm,
    input  ready, finish, mem_data, tag_out, fault
  );

  modport slave (
    input  EN, mem_w, bhw, tag_in, rs1_data, rs2_data, imm,
    output ready, finish, mem_data, tag_out, fault
  );
endinterface

// File: rtl/fu_mem_pipe.sv
// ---------------------------------------------------------------------------
// fu_mem_pipe
//   Pipelined load/store functional unit with private byte-addressable data
//   memory. An accepted op completes a fixed LATENCY edges later with a
//   one-cycle finish pulse; the op tag is passed through to writeback.
//   Loads are sign/zero-extended; stores are byte-lane enabled. Misaligned
//   halfword/word accesses, reserved funct3 codes and unsigned stores fault:
//   they still finish, with fault=1, mem_data=0 and no memory write.
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset (memory contents not reset)
//     bus       fu_mem_pipe_if.slave (issue request, ready, finish/result)
//     dbg_count remaining cycles of the in-flight op (0 = idle)
//
//   Parameters: LATENCY (1..8), DEPTH (words, power of two), TAG_W
// ---------------------------------------------------------------------------
module fu_mem_pipe #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 1024,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fu_mem_pipe_if.slave       bus,
  output logic [3:0]         dbg_count
);

  localparam int AW = $clog2(DEPTH);

  // In-flight operation registers
  logic [3:0]       cnt;
  logic             op_w;
  logic [2:0]       op_bhw;
  logic [TAG_W-1:0] op_tag;
  logic [31:0]      op_rs1;
  logic [31:0]      op_rs2;
  logic [31:0]      op_imm;

  logic [31:0]      mem [DEPTH];

  logic             completing;
  logic             accept;
  logic [31:0]      addr;
  logic [AW-1:0]    idx;
  logic [31:0]      rd_word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             fault_c;
  logic [31:0]      ld_data;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic             unused_addr_bits;

  // The op finishes on the edge where cnt goes 1 -> 0. A new request may be
  // taken on that same edge, which gives one op per LATENCY cycles and makes
  // ready constant for LATENCY=1.
  assign completing = (cnt == 4'd1);
  assign bus.ready  = (cnt == 4'd0) | completing;
  assign accept     = bus.EN & bus.ready;
  assign dbg_count  = cnt;

  // Address wraps: only the word-index bits reach the memory.
  assign addr             = op_rs1 + op_imm;
  assign idx              = addr[AW+1:2];
  assign unused_addr_bits = ^addr[31:AW+2];
  assign rd_word          = mem[idx];

  // Little-endian lane selection
  always_comb begin
    byte_sel = rd_word[7:0];
    case (addr[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
  end

  assign half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Decode of funct3: fault detection, load extension, store lanes
  always_comb begin
    fault_c = 1'b0;
    ld_data = 32'd0;
    be      = 4'b0000;
    wdata   = 32'd0;
    case (op_bhw)
      3'b000: begin
        ld_data = {{24{byte_sel[7]}}, byte_sel};
        be      = 4'b0001 << addr[1:0];
        wdata   = {4{op_rs2[7:0]}};
      end
      3'b001: begin
        fault_c = addr[0];
        ld_data = {{16{half_sel[15]}}, half_sel};
        be      = addr[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{op_rs2[15:0]}};
      end
      3'b010: begin
        fault_c = (addr[1:0] != 2'd0);
        ld_data = rd_word;
        be      = 4'b1111;
        wdata   = op_rs2;
      end
      3'b100: begin
        fault_c = op_w;
        ld_data = {24'd0, byte_sel};
      end
      3'b101: begin
        fault_c = op_w | addr[0];
        ld_data = {16'd0, half_sel};
      end
      default: fault_c = 1'b1;
    endcase
  end

  // Sequencing and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= 4'd0;
      op_w         <= 1'b0;
      op_bhw       <= 3'd0;
      op_tag       <= '0;
      op_rs1       <= 32'd0;
      op_rs2       <= 32'd0;
      op_imm       <= 32'd0;
      bus.finish   <= 1'b0;
      bus.fault    <= 1'b0;
      bus.mem_data <= 32'd0;
      bus.tag_out  <= '0;
    end else begin
      bus.finish <= completing;
      if (completing) begin
        bus.fault    <= fault_c;
        bus.tag_out  <= op_tag;
        bus.mem_data <= (op_w | fault_c) ? 32'd0 : ld_data;
      end else begin
        bus.fault    <= 1'b0;
      end

      if (accept) begin
        cnt    <= 4'(LATENCY);
        op_w   <= bus.mem_w;
        op_bhw <= bus.bhw;
        op_tag <= bus.tag_in;
        op_rs1 <= bus.rs1_data;
        op_rs2 <= bus.rs2_data;
        op_imm <= bus.imm;
      end else if (cnt != 4'd0) begin
        cnt    <= cnt - 4'd1;
      end
    end
  end

  // Store commit at the completion edge; cnt is cleared asynchronously, so
  // an op caught by reset never writes.
  always_ff @(posedge clk) begin
    if (rst_n && completing && op_w && !fault_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_fu_mem_pipe.sv
// ---------------------------------------------------------------------------
// tb_fu_mem_pipe
//   Directed bench for fu_mem_pipe (LATENCY=2, DEPTH=1024, TAG_W=4).
//   Driver tasks issue ops and push the expected {finish cycle, fault, tag,
//   data} into exp_q; an independent monitor pops on every finish pulse.
// ---------------------------------------------------------------------------
module tb_fu_mem_pipe;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 1024;
  localparam int TAG_W   = 4;
  localparam int W       = 32 + 32 + 1 + TAG_W;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dbg_count;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fu_mem_pipe_if #(.TAG_W(TAG_W)) bus ();

  fu_mem_pipe #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_count (dbg_count)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int checks    = 0;
  int failures  = 0;
  int pushes    = 0;
  int fin_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [TAG_W-1:0] t, input logic [31:0] d, input logic f);
    logic [31:0] when;
    when = 32'(cyc + 1 + LATENCY);
    exp_q.push_back({when, f, t, d});
    pushes++;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && bus.finish) begin
      fin_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_finish actual=tag %h expected=no finish", bus.tag_out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("mem_data", bus.mem_data, e[31:0]);
        chk("tag_out", 32'(bus.tag_out), 32'(e[32 +: TAG_W]));
        chk("fault", 32'(bus.fault), 32'(e[32+TAG_W]));
        chk("finish_cycle", 32'(cyc), e[33+TAG_W +: 32]);
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic w, input logic [2:0] f, input logic [TAG_W-1:0] t,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] im,
                       input logic [31:0] exp_d, input logic exp_f, input bit push);
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("ready_wait", 32'(bus.ready), 32'd1);
    if (!bus.ready) return;
    bus.mem_w    = w;
    bus.bhw      = f;
    bus.tag_in   = t;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
    bus.imm      = im;
    bus.EN       = 1'b1;
    if (push) push_exp(t, exp_d, exp_f);
    @(posedge clk);
    #1 bus.EN = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    #1;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},    32'(bus.ready),  32'd1);
    chk({tag, "_finish"},   32'(bus.finish), 32'd0);
    chk({tag, "_fault"},    32'(bus.fault),  32'd0);
    chk({tag, "_mem_data"}, bus.mem_data,    32'd0);
    chk({tag, "_tag_out"},  32'(bus.tag_out), 32'd0);
  endtask

  // Stimulus
  logic [5:0] rdy_pat = 6'b010101;

  initial begin
    bus.EN = 1'b0; bus.mem_w = 1'b0; bus.bhw = 3'd0; bus.tag_in = '0;
    bus.rs1_data = 32'd0; bus.rs2_data = 32'd0; bus.imm = 32'd0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // SW then LW at 0x104; the load is taken in the store's finish cycle
    issue(1, 3'b010, 4'd1, 32'h100, 32'hDEADBEEF, 32'd4, 32'h0, 0, 1);
    issue(0, 3'b010, 4'd2, 32'h100, 32'h0, 32'd4, 32'hDEADBEEF, 0, 1);

    // SB 0x80 at 0x105, byte/halfword loads
    issue(1, 3'b000, 4'd3, 32'h100, 32'h00000080, 32'd5, 32'h0, 0, 1);
    issue(0, 3'b000, 4'd4, 32'h100, 32'h0, 32'd5, 32'hFFFFFF80, 0, 1);
    issue(0, 3'b100, 4'd5, 32'h100, 32'h0, 32'd5, 32'h00000080, 0, 1);
    issue(0, 3'b010, 4'd6, 32'h104, 32'h0, 32'd0, 32'hDEAD80EF, 0, 1);
    issue(0, 3'b001, 4'd7, 32'h104, 32'h0, 32'd2, 32'hFFFFDEAD, 0, 1);
    issue(0, 3'b101, 4'd8, 32'h104, 32'h0, 32'd0, 32'h000080EF, 0, 1);
    issue(1, 3'b001, 4'd9, 32'h104, 32'hABCD1234, 32'd2, 32'h0, 0, 1);
    issue(0, 3'b010, 4'd10, 32'h104, 32'h0, 32'd0, 32'h123480EF, 0, 1);

    // Faults: misaligned, reserved funct3, unsigned store
    issue(1, 3'b010, 4'd11, 32'h100, 32'hCAFEF00D, 32'd0, 32'h0, 0, 1);
    issue(0, 3'b001, 4'd12, 32'h100, 32'h0, 32'd3, 32'h0, 1, 1);
    issue(1, 3'b010, 4'd13, 32'h100, 32'h12345678, 32'd2, 32'h0, 1, 1);
    issue(0, 3'b010, 4'd14, 32'h100, 32'h0, 32'd0, 32'hCAFEF00D, 0, 1);
    issue(0, 3'b011, 4'd15, 32'h104, 32'h0, 32'd0, 32'h0, 1, 1);
    issue(1, 3'b100, 4'd1, 32'h104, 32'h000000FF, 32'd0, 32'h0, 1, 1);
    issue(0, 3'b010, 4'd2, 32'h104, 32'h0, 32'd0, 32'h123480EF, 0, 1);

    // EN held high: only every other cycle is accepted
    drain();
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("busy_ready_c%0d", c), 32'(bus.ready), 32'(rdy_pat[c]));
      bus.mem_w    = 1'b0;
      bus.bhw      = 3'b010;
      bus.tag_in   = 4'(c);
      bus.rs1_data = 32'h104;
      bus.rs2_data = 32'h0;
      bus.imm      = 32'd0;
      bus.EN       = 1'b1;
      if (rdy_pat[c]) push_exp(4'(c), 32'h123480EF, 1'b0);
      @(negedge clk);
    end
    bus.EN = 1'b0;

    // Reset aborts an in-flight store
    drain();
    issue(1, 3'b010, 4'd3, 32'h104, 32'h55555555, 32'd0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 3'b010, 4'd4, 32'h104, 32'h0, 32'd0, 32'h123480EF, 0, 1);

    // Address wrap to word index 1
    issue(1, 3'b010, 4'd5, 32'hFFFFFFFC, 32'hA5A51234, 32'd8, 32'h0, 0, 1);
    issue(0, 3'b010, 4'd6, 32'h0, 32'h0, 32'd4, 32'hA5A51234, 0, 1);
    issue(0, 3'b010, 4'd7, 32'h1000, 32'h0, 32'd4, 32'hA5A51234, 0, 1);

    drain();
    repeat (4) @(negedge clk);
    chk("finish_count", 32'(fin_count), 32'(pushes));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait ever runs away
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
